// File: rtl/rs_pkg.sv
// Shared configuration defaults and the entry payload type for the reservation station.
package rs_pkg;

    localparam int unsigned RS_DEPTH   = 5;
    localparam int unsigned RS_NUM_FWD = 4;
    localparam int unsigned RS_DATA_W  = 16;
    localparam int unsigned RS_TAG_W   = 6;
    localparam int unsigned RS_OP_W    = 4;

    typedef struct packed {
        logic                 valid;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  rob;
        logic [RS_TAG_W-1:0]  tag_a;
        logic [RS_TAG_W-1:0]  tag_b;
        logic [RS_DATA_W-1:0] val_a;
        logic [RS_DATA_W-1:0] val_b;
        logic                 pend_a;
        logic                 pend_b;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first picker: grants the ready entry that has no ready entry older than itself.
module rs_age_select #(
    parameter int unsigned DEPTH = 5
) (
    input  logic [DEPTH-1:0]            ready_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] older_i,
    output logic [DEPTH-1:0]            grant_o,
    output logic                        any_ready_o
);

    always_comb begin
        grant_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            grant_o[i] = ready_i[i] & ~(|(ready_i & older_i[i]));
        end
        any_ready_o = |ready_i;
    end

endmodule

// File: rtl/reservation_station_param.sv
// Reservation station: buffers dispatched ops, captures forwarded operands, issues oldest ready.
module reservation_station_param
    import rs_pkg::*;
#(
    parameter int unsigned DEPTH   = RS_DEPTH,
    parameter int unsigned NUM_FWD = RS_NUM_FWD,
    parameter int unsigned DATA_W  = RS_DATA_W,
    parameter int unsigned TAG_W   = RS_TAG_W,
    parameter int unsigned OP_W    = RS_OP_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OP_W-1:0]             in_op,
    input  logic [TAG_W-1:0]            in_rob,
    input  logic [TAG_W-1:0]            in_tag_a,
    input  logic [TAG_W-1:0]            in_tag_b,
    input  logic [DATA_W-1:0]           in_val_a,
    input  logic [DATA_W-1:0]           in_val_b,
    input  logic                        in_pend_a,
    input  logic                        in_pend_b,
    input  logic [NUM_FWD-1:0]          fwd_valid,
    input  logic [NUM_FWD*TAG_W-1:0]    fwd_tag,
    input  logic [NUM_FWD*DATA_W-1:0]   fwd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OP_W-1:0]             out_op,
    output logic [TAG_W-1:0]            out_rob,
    output logic [DATA_W-1:0]           out_val_a,
    output logic [DATA_W-1:0]           out_val_b,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rob;
        logic [TAG_W-1:0]  tag_a;
        logic [TAG_W-1:0]  tag_b;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic              pend_a;
        logic              pend_b;
    } entry_t;

    entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic   [DEPTH-1:0][DEPTH-1:0] older_q, older_d;
    logic   [CNT_W-1:0]            count_q, count_d;

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] free_oh;
    logic [DEPTH-1:0] grant;
    logic             any_ready;
    logic             do_disp;
    logic             do_issue;
    entry_t           new_ent;
    logic [DATA_W:0]  lk_a;
    logic [DATA_W:0]  lk_b;

    // Returns {hit, data}; the lowest-numbered matching bus wins.
    function automatic logic [DATA_W:0] fwd_lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = '0;
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
            if (!res[DATA_W] && fwd_valid[k] && (fwd_tag[k*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, fwd_data[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            ready_vec[i] = ent_q[i].valid & ~ent_q[i].pend_a & ~ent_q[i].pend_b;
        end
    end

    // Lowest-index free slot as a one-hot vector.
    assign free_oh  = ~valid_vec & (valid_vec + DEPTH'(1));
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign do_disp  = in_valid & in_ready & ~flush;
    assign do_issue = any_ready & out_ready & ~flush;
    assign count    = count_q;

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .ready_i     (ready_vec),
        .older_i     (older_q),
        .grant_o     (grant),
        .any_ready_o (any_ready)
    );

    // Incoming entry, with operands resolved by a same-cycle broadcast.
    always_comb begin
        lk_a           = fwd_lookup(in_tag_a);
        lk_b           = fwd_lookup(in_tag_b);
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.op     = in_op;
        new_ent.rob    = in_rob;
        new_ent.tag_a  = in_tag_a;
        new_ent.tag_b  = in_tag_b;
        new_ent.val_a  = in_val_a;
        new_ent.val_b  = in_val_b;
        new_ent.pend_a = in_pend_a;
        new_ent.pend_b = in_pend_b;
        if (in_pend_a && lk_a[DATA_W]) begin
            new_ent.val_a  = lk_a[DATA_W-1:0];
            new_ent.pend_a = 1'b0;
        end
        if (in_pend_b && lk_b[DATA_W]) begin
            new_ent.val_b  = lk_b[DATA_W-1:0];
            new_ent.pend_b = 1'b0;
        end
    end

    always_comb begin
        logic [DATA_W:0] lk;
        lk      = '0;
        ent_d   = ent_q;
        older_d = older_q;
        count_d = count_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].pend_a) begin
                lk = fwd_lookup(ent_q[i].tag_a);
                if (lk[DATA_W]) begin
                    ent_d[i].val_a  = lk[DATA_W-1:0];
                    ent_d[i].pend_a = 1'b0;
                end
            end
            if (ent_q[i].valid && ent_q[i].pend_b) begin
                lk = fwd_lookup(ent_q[i].tag_b);
                if (lk[DATA_W]) begin
                    ent_d[i].val_b  = lk[DATA_W-1:0];
                    ent_d[i].pend_b = 1'b0;
                end
            end
            if (do_issue && grant[i]) begin
                ent_d[i].valid = 1'b0;
            end
        end

        // New entry is younger than everything currently valid.
        if (do_disp) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (free_oh[i]) begin
                    ent_d[i]   = new_ent;
                    older_d[i] = valid_vec;
                end
            end
            for (int unsigned r = 0; r < DEPTH; r++) begin
                older_d[r] = older_d[r] & ~free_oh;
            end
        end

        if (do_disp && !do_issue) begin
            count_d = count_q + CNT_W'(1);
        end else if (!do_disp && do_issue) begin
            count_d = count_q - CNT_W'(1);
        end

        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
            end
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q   <= '0;
            older_q <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            older_q <= older_d;
            count_q <= count_d;
        end
    end

    // Issue port is zero whenever nothing is granted.
    always_comb begin
        out_valid = any_ready;
        out_op    = '0;
        out_rob   = '0;
        out_val_a = '0;
        out_val_b = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                out_op    = out_op | ent_q[i].op;
                out_rob   = out_rob | ent_q[i].rob;
                out_val_a = out_val_a | ent_q[i].val_a;
                out_val_b = out_val_b | ent_q[i].val_b;
            end
        end
    end

endmodule

// File: tb/tb_reservation_station_param.sv
// Scoreboard bench for reservation_station_param against a queue-ordered reference model.
module tb_reservation_station_param;
    import rs_pkg::*;

    localparam int unsigned DEPTH = RS_DEPTH;
    localparam int unsigned NF    = RS_NUM_FWD;
    localparam int unsigned DW    = RS_DATA_W;
    localparam int unsigned TW    = RS_TAG_W;
    localparam int unsigned OW    = RS_OP_W;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [OW-1:0]    in_op;
    logic [TW-1:0]    in_rob;
    logic [TW-1:0]    in_tag_a;
    logic [TW-1:0]    in_tag_b;
    logic [DW-1:0]    in_val_a;
    logic [DW-1:0]    in_val_b;
    logic             in_pend_a;
    logic             in_pend_b;
    logic [NF-1:0]    fwd_valid;
    logic [NF*TW-1:0] fwd_tag;
    logic [NF*DW-1:0] fwd_data;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_op;
    logic [TW-1:0]    out_rob;
    logic [DW-1:0]    out_val_a;
    logic [DW-1:0]    out_val_b;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    reservation_station_param dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rob    (in_rob),
        .in_tag_a  (in_tag_a),
        .in_tag_b  (in_tag_b),
        .in_val_a  (in_val_a),
        .in_val_b  (in_val_b),
        .in_pend_a (in_pend_a),
        .in_pend_b (in_pend_b),
        .fwd_valid (fwd_valid),
        .fwd_tag   (fwd_tag),
        .fwd_data  (fwd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_rob   (out_rob),
        .out_val_a (out_val_a),
        .out_val_b (out_val_b),
        .count     (count)
    );

    typedef struct {
        logic          v;
        logic [OW-1:0] op;
        logic [TW-1:0] rob;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            cnt;
        logic          rdy;
    } exp_t;

    exp_t      exp_q[$];
    rs_entry_t mq[$];
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit bus_hit(input logic [TW-1:0] t, output logic [DW-1:0] d);
        d = '0;
        for (int k = 0; k < int'(NF); k++) begin
            if (fwd_valid[k] && fwd_tag[k*TW +: TW] == t) begin
                d = fwd_data[k*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int oldest_ready();
        foreach (mq[i]) begin
            if (!mq[i].pend_a && !mq[i].pend_b) return i;
        end
        return -1;
    endfunction

    // Model: list in arrival order; the first ready element is the one to issue.
    task automatic model_step();
        int             idx;
        int             n;
        logic [DW-1:0]  d;
        rs_entry_t      ne;
        idx = oldest_ready();
        n   = mq.size();
        if (flush) begin
            mq.delete();
            return;
        end
        if (idx >= 0 && out_ready) mq.delete(idx);
        foreach (mq[i]) begin
            if (mq[i].pend_a && bus_hit(mq[i].tag_a, d)) begin
                mq[i].val_a  = d;
                mq[i].pend_a = 1'b0;
            end
            if (mq[i].pend_b && bus_hit(mq[i].tag_b, d)) begin
                mq[i].val_b  = d;
                mq[i].pend_b = 1'b0;
            end
        end
        if (in_valid && n < int'(DEPTH)) begin
            ne        = '0;
            ne.valid  = 1'b1;
            ne.op     = in_op;
            ne.rob    = in_rob;
            ne.tag_a  = in_tag_a;
            ne.tag_b  = in_tag_b;
            ne.val_a  = in_val_a;
            ne.val_b  = in_val_b;
            ne.pend_a = in_pend_a;
            ne.pend_b = in_pend_b;
            if (in_pend_a && bus_hit(in_tag_a, d)) begin
                ne.val_a  = d;
                ne.pend_a = 1'b0;
            end
            if (in_pend_b && bus_hit(in_tag_b, d)) begin
                ne.val_b  = d;
                ne.pend_b = 1'b0;
            end
            mq.push_back(ne);
        end
    endtask

    task automatic cycle();
        exp_t e;
        int   idx;
        idx   = oldest_ready();
        e.v   = (idx >= 0);
        e.op  = (idx >= 0) ? mq[idx].op    : '0;
        e.rob = (idx >= 0) ? mq[idx].rob   : '0;
        e.a   = (idx >= 0) ? mq[idx].val_a : '0;
        e.b   = (idx >= 0) ? mq[idx].val_b : '0;
        e.cnt = mq.size();
        e.rdy = (mq.size() < int'(DEPTH));
        exp_q.push_back(e);
        model_step();
        @(negedge clk);
    endtask

    task automatic clr_in();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_rob    = '0;
        in_tag_a  = '0;
        in_tag_b  = '0;
        in_val_a  = '0;
        in_val_b  = '0;
        in_pend_a = 1'b0;
        in_pend_b = 1'b0;
        fwd_valid = '0;
        fwd_tag   = '0;
        fwd_data  = '0;
    endtask

    task automatic set_disp(input int op, input int rob, input int ta, input int tb, input int va,
                            input int vb, input bit pa, input bit pb);
        in_valid  = 1'b1;
        in_op     = OW'(op);
        in_rob    = TW'(rob);
        in_tag_a  = TW'(ta);
        in_tag_b  = TW'(tb);
        in_val_a  = DW'(va);
        in_val_b  = DW'(vb);
        in_pend_a = pa;
        in_pend_b = pb;
    endtask

    task automatic set_fwd(input int k, input int tag, input int data);
        fwd_valid[k]          = 1'b1;
        fwd_tag[k*TW +: TW]   = TW'(tag);
        fwd_data[k*DW +: DW]  = DW'(data);
    endtask

    // Monitor: compares DUT outputs with the expectation queued for this cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", 32'(out_valid), 32'(e.v));
                chk("out_op",    32'(out_op),    32'(e.op));
                chk("out_rob",   32'(out_rob),   32'(e.rob));
                chk("out_val_a", 32'(out_val_a), 32'(e.a));
                chk("out_val_b", 32'(out_val_b), 32'(e.b));
                chk("count",     32'(count),     32'(e.cnt));
                chk("in_ready",  32'(in_ready),  32'(e.rdy));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        clr_in();
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #12;
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_rob",   32'(out_rob),   32'd0);
        chk("rst_out_val_a", 32'(out_val_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();

        // Basic dispatch and issue
        set_disp(3, 5, 0, 0, 'h0011, 'h0022, 0, 0);
        cycle();
        clr_in();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_rob",   32'(out_rob),   32'd5);
        chk("t1_op",    32'(out_op),    32'd3);
        chk("t1_val_a", 32'(out_val_a), 32'h0011);
        chk("t1_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        cycle();
        chk("t1_count_after", 32'(count),     32'd0);
        chk("t1_idle_valid",  32'(out_valid), 32'd0);

        // Wakeup from bus 2, then lowest bus wins
        set_disp(1, 10, 9, 0, 0, 'h22, 1, 0);
        cycle();
        clr_in();
        chk("t2_pending", 32'(out_valid), 32'd0);
        cycle();
        set_fwd(2, 9, 'hBEEF);
        cycle();
        clr_in();
        chk("t2_woke",  32'(out_valid), 32'd1);
        chk("t2_val_a", 32'(out_val_a), 32'hBEEF);
        chk("t2_rob",   32'(out_rob),   32'd10);
        cycle();
        set_disp(2, 11, 9, 0, 0, 0, 1, 0);
        cycle();
        clr_in();
        set_fwd(0, 9, 'h1111);
        set_fwd(3, 9, 'h3333);
        cycle();
        clr_in();
        chk("t2_lowbus", 32'(out_val_a), 32'h1111);
        cycle();

        // Same-cycle dispatch bypass on operand B
        set_disp(4, 12, 0, 4, 'h5, 0, 0, 1);
        set_fwd(1, 4, 'h4444);
        cycle();
        clr_in();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_val_b", 32'(out_val_b), 32'h4444);
        chk("t3_rob",   32'(out_rob),   32'd12);
        cycle();

        // Fill to capacity, then drain in age order
        out_ready = 1'b0;
        for (int r = 1; r <= int'(DEPTH); r++) begin
            set_disp(5, r, 0, 0, r * 16, r, 0, 0);
            cycle();
        end
        clr_in();
        chk("t4_count_full", 32'(count),    32'(DEPTH));
        chk("t4_not_ready",  32'(in_ready), 32'd0);
        set_disp(5, 6, 0, 0, 0, 0, 0, 0);
        cycle();
        clr_in();
        chk("t4_drop_full", 32'(count), 32'(DEPTH));
        out_ready = 1'b1;
        for (int r = 1; r <= int'(DEPTH); r++) begin
            chk("t4_order", 32'(out_rob), 32'(r));
            cycle();
        end
        chk("t4_drained", 32'(count), 32'd0);

        // Younger ready entry bypasses an older pending one
        out_ready = 1'b0;
        set_disp(6, 7, 20, 0, 0, 'h77, 1, 0);
        cycle();
        set_disp(6, 8, 0, 0, 'h8, 'h88, 0, 0);
        cycle();
        clr_in();
        chk("t5_young_first", 32'(out_rob), 32'd8);
        out_ready = 1'b1;
        cycle();
        chk("t5_old_wait", 32'(out_valid), 32'd0);
        set_fwd(0, 20, 'h7777);
        cycle();
        clr_in();
        chk("t5_old_rob",   32'(out_rob),   32'd7);
        chk("t5_old_val_a", 32'(out_val_a), 32'h7777);
        cycle();

        // Flush overrides a concurrent dispatch
        out_ready = 1'b0;
        for (int r = 20; r < 23; r++) begin
            set_disp(1, r, 0, 0, r, r, 0, 0);
            cycle();
        end
        chk("t6_count3", 32'(count), 32'd3);
        set_disp(1, 23, 0, 0, 1, 1, 0, 0);
        flush = 1'b1;
        cycle();
        clr_in();
        chk("t6_flush_count", 32'(count),     32'd0);
        chk("t6_flush_valid", 32'(out_valid), 32'd0);
        cycle();

        // Asynchronous reset between edges
        set_disp(2, 30, 0, 0, 1, 2, 0, 0);
        cycle();
        set_disp(2, 31, 0, 0, 3, 4, 0, 0);
        cycle();
        clr_in();
        chk("t7_count2", 32'(count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_count", 32'(count),     32'd0);
        chk("t7_rst_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_ready", 32'(in_ready),  32'd1);
        chk("t7_rst_rob",   32'(out_rob),   32'd0);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            clr_in();
            if ($urandom_range(0, 99) < 60) begin
                set_disp(int'($urandom_range(0, 15)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                         int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            for (int k = 0; k < int'(NF); k++) begin
                if ($urandom_range(0, 99) < 30) begin
                    set_fwd(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
                end
            end
            flush     = ($urandom_range(0, 199) == 0);
            out_ready = ($urandom_range(0, 99) < 70);
            cycle();
        end

        clr_in();
        @(negedge clk);
        #5;
        if (exp_q.size() != 0) chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reservation_station_param.md
# reservation_station_param

Parametrised, handshaked reservation station for the out-of-order core; sits between rename/dispatch and one functional unit. It buffers up to DEPTH operations and captures operand values from NUM_FWD result-broadcast buses, including on the dispatch cycle. It issues the oldest fully-ready entry over a valid/ready interface and frees that entry on issue. It supports a pipeline flush.

## Interface
- DEPTH, 5, entry count (≥2)
- NUM_FWD, 4, forwarding buses
- DATA_W, 16, operand width
- TAG_W, 6, ROB tag width
- OP_W, 4, opcode width

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  free entry exists
- in_op  in  OP_W  opcode
- in_rob  in  TAG_W  destination ROB tag
- in_tag_a, in_tag_b  in  TAG_W  producer tags
- in_val_a, in_val_b  in  DATA_W  operand values (meaningful when not pending)
- in_pend_a, in_pend_b  in  1  operand waiting on tag
- fwd_valid  in  NUM_FWD  per-bus broadcast valid
- fwd_tag  in  NUM_FWD*TAG_W  bus k at [k*TAG_W +: TAG_W]
- fwd_data  in  NUM_FWD*DATA_W  bus k at [k*DATA_W +: DATA_W]
- out_valid  out  1  an entry is ready to issue
- out_ready  in  1  functional unit accepts
- out_op, out_rob  out  OP_W/TAG_W  issued entry fields
- out_val_a, out_val_b  out  DATA_W  issued operands
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Entry = {valid, op, rob, tag_a, tag_b, val_a, val_b, pend_a, pend_b}. Age matrix: older[i][j]=1 means j is older than i.
- in_ready = count < DEPTH, from registered state only. An entry freed this cycle is not reusable this cycle.
- Dispatch (in_valid & in_ready & !flush) writes the lowest-index free entry. It sets older[i][*] = current valid vector and clears column i.
- Dispatch bypass: if in_pend_x and some fwd_valid[k] with fwd_tag[k]==in_tag_x, the entry stores fwd_data[k] with pend_x=0.
- Wakeup: for each valid entry and each pending operand, a tag match on any valid bus captures data and clears pend. If several buses match, the lowest k wins. Operands A and B are independent, and one bus may wake both.
- Ready = valid & !pend_a & !pend_b. Selection: the ready entry with no ready older entry (oldest-first).
- out_valid = any ready. out_* are combinational from the selected entry's registers. When out_valid=0, out_* are all zero.
- On out_valid & out_ready the selected entry's valid is cleared. Dispatch and issue in the same cycle are allowed. Count changes by +1, −1, or 0 accordingly.
- flush: all valid cleared next edge; overrides both dispatch and issue in that cycle; count → 0.
- Tag compare is exact on TAG_W bits; no wrap handling needed.

## Timing
- Reset (async assert, sync release is external): all valid=0, pend=0, age matrix=0. Outputs: count=0, in_ready=1, out_valid=0, out_*=0.
- Dispatch with no pending operands at edge t → out_valid high after edge t (next cycle). Minimum dispatch-to-issue latency is 1 cycle.
- Forward at edge t resolving the last pending operand → issuable in cycle t+1. No same-cycle forward-to-issue path.
- Full (count==DEPTH): in_ready=0 even if issuing that cycle.
- out_valid & !out_ready: the selection may change next cycle if an older entry wakes. No stability is guaranteed to the consumer except after handshake.
- Reset mid-operation: immediate clear, no issue.

## Structure
- Package rs_pkg: DATA_W/TAG_W/OP_W defaults and the rs_entry_t struct typedef.
- Sub-module rs_age_select: inputs the DEPTH ready vector and the age matrix; outputs a one-hot grant and any_ready. Purely combinational.
- Top holds the entry array, age matrix, allocation priority encoder, wakeup loops, and counter.

## Test plan
- Reset, then dispatch op=3 rob=5 val_a=0x0011 val_b=0x0022 with no pending → next cycle out_valid=1, out_rob=5, out_val_a=0x0011; out_ready=1 → count 1→0.
- Dispatch pend_a tag_a=9. Pulse fwd bus 2 tag 9 data 0xBEEF → out_valid next cycle with out_val_a=0xBEEF. Buses 0 and 3 both tag 9 with differing data → bus 0 data captured.
- Dispatch pend_b tag 4 while bus 1 broadcasts tag 4 in the same cycle → entry stored ready; issues next cycle with that data.
- Fill DEPTH=5 entries (rob 1..5, all ready), hold out_ready=0 → in_ready=0, count=5. Release out_ready → issue order rob 1,2,3,4,5.
- Entries rob 7 (older, pending) and rob 8 (ready): rob 8 issues first; wake rob 7 → issues after.
- Three entries then flush with in_valid=1 → count=0, out_valid=0, dispatched op dropped. Assert rst_n low mid-stream → outputs at reset values immediately.
